// File: rtl/instr_fetch_if.sv
// Instruction-fetch bus: memory read port, redirect request and decode-side handshake.
// master = fetch unit, slave = memory/decode/branch environment.
interface instr_fetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_instruction;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_address;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_instruction;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic                  out_ready;
    logic                  halted;

    modport master (
        output mem_address,
        input  mem_instruction,
        input  redirect_valid,
        input  redirect_address,
        output out_valid,
        output out_instruction,
        output out_pc,
        input  out_ready,
        output halted
    );

    modport slave (
        input  mem_address,
        output mem_instruction,
        output redirect_valid,
        output redirect_address,
        input  out_valid,
        input  out_instruction,
        input  out_pc,
        output out_ready,
        input  halted
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch unit: owns the PC, reads a combinational instruction memory and queues
// {pc, instruction} pairs in a 2-entry FIFO toward decode, with redirect and halt.
//
// state    | meaning
// ST_FETCH | issuing addresses, pushing into the buffer when space (or a pop) allows
// ST_HALT  | past the last valid address or redirected out of range; buffer drains only
module instr_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    MEM_DEPTH  = 11
) (
    input logic             clk,
    input logic             reset_n,
    instr_fetch_if.master   bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [1:0]            count_q, count_d;
    logic [ADDR_WIDTH-1:0] head_pc_q, head_pc_d;
    logic [DATA_WIDTH-1:0] head_instr_q, head_instr_d;
    logic [ADDR_WIDTH-1:0] tail_pc_q, tail_pc_d;
    logic [DATA_WIDTH-1:0] tail_instr_q, tail_instr_d;
    logic                  pop;
    logic                  push;
    logic                  fill_head;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            count_q      <= 2'd0;
            head_pc_q    <= '0;
            head_instr_q <= '0;
            tail_pc_q    <= '0;
            tail_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            count_q      <= count_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            tail_pc_q    <= tail_pc_d;
            tail_instr_q <= tail_instr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        count_d      = count_q;
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        tail_pc_d    = tail_pc_q;
        tail_instr_d = tail_instr_q;

        pop       = (count_q != 2'd0) && bus.out_ready;
        push      = (state_q == ST_FETCH) && ((count_q != 2'd2) || pop);
        // New entry lands in the head slot only if the buffer is empty after this pop.
        fill_head = (count_q == 2'd0) || ((count_q == 2'd1) && pop);

        if (bus.redirect_valid) begin
            count_d = 2'd0;
            pc_d    = bus.redirect_address;
            state_d = (bus.redirect_address > LAST_ADDR) ? ST_HALT : ST_FETCH;
        end else begin
            if (pop) begin
                head_pc_d    = tail_pc_q;
                head_instr_d = tail_instr_q;
            end
            if (push) begin
                if (fill_head) begin
                    head_pc_d    = pc_q;
                    head_instr_d = bus.mem_instruction;
                end else begin
                    tail_pc_d    = pc_q;
                    tail_instr_d = bus.mem_instruction;
                end
                pc_d = pc_q + 1'b1;
                if (pc_q == LAST_ADDR) begin
                    state_d = ST_HALT;
                end
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus.mem_address     = pc_q;
    assign bus.out_valid       = (count_q != 2'd0);
    assign bus.out_pc          = head_pc_q;
    assign bus.out_instruction = head_instr_q;
    assign bus.halted          = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: 4-word memory, streaming, back-pressure,
// redirects (in range, out of range, out of halt) and mid-stream reset.
module tb_instr_fetch;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    logic [31:0] mem [16];

    instr_fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    instr_fetch #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .RESET_PC  (32'd0),
        .MEM_DEPTH (4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    assign bus.mem_instruction = (bus.mem_address < 32'd16) ? mem[bus.mem_address[3:0]]
                                                            : 32'hBAD0_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, " valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, " pc"}, bus.out_pc, pc);
        chk({tag, " instr"}, bus.out_instruction, mem[pc[3:0]]);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mem[0] = 32'h0000;
        mem[1] = 32'h1111;
        mem[2] = 32'h2222;
        mem[3] = 32'h3333;
        for (int i = 4; i < 16; i++) mem[i] = 32'hDEAD_0000 + i;

        bus.redirect_valid   = 1'b0;
        bus.redirect_address = '0;
        bus.out_ready        = 1'b0;
        reset_n              = 1'b0;
        step();
        step();
        chk("rst valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst pc", bus.out_pc, 32'd0);
        chk("rst instr", bus.out_instruction, 32'd0);
        chk("rst halted", {31'd0, bus.halted}, 32'd0);
        chk("rst addr", bus.mem_address, 32'd0);

        // Streaming at one instruction per cycle up to halt.
        reset_n       = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_head("stream", i[31:0]);
            chk("stream halted", {31'd0, bus.halted}, (i == 3) ? 32'd1 : 32'd0);
        end
        step();
        chk("drained valid", {31'd0, bus.out_valid}, 32'd0);
        chk("drained halted", {31'd0, bus.halted}, 32'd1);
        chk("drained addr", bus.mem_address, 32'd4);

        // Back-pressure: buffer fills to 2 and PC holds.
        bus.out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            chk_head("stall", 32'd0);
            chk("stall addr", bus.mem_address, (i == 0) ? 32'd1 : 32'd2);
        end
        bus.out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            chk_head("release", i[31:0]);
        end
        chk("release halted", {31'd0, bus.halted}, 32'd1);
        step();
        chk("release empty", {31'd0, bus.out_valid}, 32'd0);

        // Redirect out of halt with an empty buffer.
        bus.redirect_valid   = 1'b1;
        bus.redirect_address = 32'd0;
        step();
        bus.redirect_valid = 1'b0;
        chk("unhalt halted", {31'd0, bus.halted}, 32'd0);
        chk("unhalt valid", {31'd0, bus.out_valid}, 32'd0);
        chk("unhalt addr", bus.mem_address, 32'd0);
        step();
        chk_head("unhalt", 32'd0);
        step();
        chk_head("unhalt", 32'd1);
        step();
        chk_head("pre-redir", 32'd2);

        // Redirect back to 1 while head is pc 2: pc 2 is dropped.
        bus.redirect_valid   = 1'b1;
        bus.redirect_address = 32'd1;
        step();
        bus.redirect_valid = 1'b0;
        chk("redir flush valid", {31'd0, bus.out_valid}, 32'd0);
        chk("redir addr", bus.mem_address, 32'd1);
        step();
        chk_head("redir", 32'd1);
        step();
        chk_head("redir", 32'd2);

        // Redirect beyond the last valid address.
        bus.redirect_valid   = 1'b1;
        bus.redirect_address = 32'd7;
        step();
        bus.redirect_valid = 1'b0;
        chk("oor valid", {31'd0, bus.out_valid}, 32'd0);
        chk("oor halted", {31'd0, bus.halted}, 32'd1);
        step();
        chk("oor valid2", {31'd0, bus.out_valid}, 32'd0);
        chk("oor halted2", {31'd0, bus.halted}, 32'd1);
        chk("oor addr", bus.mem_address, 32'd7);

        // Fill the buffer, then reset with a redirect also pending.
        bus.redirect_valid   = 1'b1;
        bus.redirect_address = 32'd0;
        bus.out_ready        = 1'b0;
        step();
        bus.redirect_valid = 1'b0;
        step();
        step();
        chk_head("full", 32'd0);
        chk("full addr", bus.mem_address, 32'd2);
        reset_n              = 1'b0;
        bus.redirect_valid   = 1'b1;
        bus.redirect_address = 32'd3;
        step();
        reset_n            = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b1;
        chk("midrst valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst addr", bus.mem_address, 32'd0);
        chk("midrst halted", {31'd0, bus.halted}, 32'd0);
        step();
        chk_head("restart", 32'd0);
        step();
        chk_head("restart", 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
